// File: rtl/vending_pkg.sv
// Shared types and constants for the coin credit controller.
package vending_pkg;

    localparam int unsigned CREDIT_W = 7;

    typedef logic [CREDIT_W-1:0] credit_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_CHANGE = 1'b1
    } state_e;

    // Coin values in 100-won units
    localparam credit_t COIN_100_VAL  = credit_t'(1);
    localparam credit_t COIN_500_VAL  = credit_t'(5);
    localparam credit_t COIN_1000_VAL = credit_t'(10);

    // Total value of the coin pulses seen in one cycle (maximum 16)
    function automatic credit_t coin_sum(input logic c100, input logic c500, input logic c1000);
        credit_t s;
        s = '0;
        if (c100)  s = s + COIN_100_VAL;
        if (c500)  s = s + COIN_500_VAL;
        if (c1000) s = s + COIN_1000_VAL;
        return s;
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// Change payout sequencer: loads the refunded amount and emits one change coin
// per cycle (500 while at least 5 remain, otherwise 100) until nothing is left.
module change_dispenser
    import vending_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [CREDIT_W-1:0] amount_i,
    output logic                change_500_o,
    output logic                change_100_o,
    output logic                busy_o,
    output logic [CREDIT_W-1:0] remaining_o,
    output logic                done_o
);

    credit_t remaining_q;
    credit_t remaining_d;
    credit_t src;
    logic    emit;
    logic    big;
    logic    c500_q;
    logic    c100_q;
    logic    busy_q;

    // Pick the coin for this cycle; a load pays out its first coin immediately
    always_comb begin
        src         = load_i ? amount_i : remaining_q;
        emit        = (load_i || busy_q) && (src != '0);
        big         = (src >= COIN_500_VAL);
        remaining_d = remaining_q;
        if (emit) begin
            remaining_d = src - (big ? COIN_500_VAL : COIN_100_VAL);
        end
    end

    // Payout state; busy is held one extra cycle after the last coin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining_q <= '0;
            c500_q      <= 1'b0;
            c100_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            c500_q      <= emit && big;
            c100_q      <= emit && !big;
            busy_q      <= emit;
        end
    end

    assign change_500_o = c500_q;
    assign change_100_o = c100_q;
    assign busy_o       = busy_q;
    assign remaining_o  = remaining_q;
    assign done_o       = busy_q && (remaining_q == '0);

endmodule

// File: rtl/coin_credit_ctrl.sv
// Coin credit controller: accumulates coins, vends items against credit and
// hands the balance back as change coins on refund.
module coin_credit_ctrl
    import vending_pkg::*;
#(
    parameter int unsigned MAX_CREDIT = 99,
    parameter int unsigned PRICE0     = 3,
    parameter int unsigned PRICE1     = 5,
    parameter int unsigned PRICE2     = 8,
    parameter int unsigned PRICE3     = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_100,
    input  logic                coin_500,
    input  logic                coin_1000,
    input  logic                buy,
    input  logic [1:0]          item_sel,
    input  logic                refund,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic [1:0]          dispense_item,
    output logic                deny,
    output logic                coin_return,
    output logic                change_500,
    output logic                change_100,
    output logic                busy
);

    localparam logic [CREDIT_W:0] MAX_W = (CREDIT_W+1)'(MAX_CREDIT);

    state_e           state_q;
    credit_t          credit_q;
    logic             dispense_q;
    logic [1:0]       dispense_item_q;
    logic             deny_q;
    logic             coin_return_q;

    logic             coin_any;
    credit_t          coin_val;
    credit_t          price;
    logic             buy_ok;
    credit_t          post_buy;
    logic [CREDIT_W:0] coin_total;
    logic             coin_ok;
    logic             refund_go;

    logic             chg_busy;
    logic             chg_done;
    credit_t          chg_remaining;

    // Purchase and coin-acceptance decisions from the pre-cycle credit
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        coin_any = coin_100 | coin_500 | coin_1000;
        coin_val = coin_sum(coin_100, coin_500, coin_1000);
        price    = credit_t'(PRICE0);
        case (item_sel)
            2'd0:    price = credit_t'(PRICE0);
            2'd1:    price = credit_t'(PRICE1);
            2'd2:    price = credit_t'(PRICE2);
            default: price = credit_t'(PRICE3);
        endcase
        buy_ok     = buy && (credit_q >= price);
        post_buy   = buy_ok ? (credit_q - price) : credit_q;
        coin_total = {1'b0, post_buy} + {1'b0, coin_val};
        coin_ok    = (coin_total <= MAX_W);
        refund_go  = (state_q == ST_IDLE) && refund && (credit_q != '0);
    end

    // Main FSM with registered response pulses
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            credit_q        <= '0;
            dispense_q      <= 1'b0;
            dispense_item_q <= 2'd0;
            deny_q          <= 1'b0;
            coin_return_q   <= 1'b0;
        end else begin
            dispense_q      <= 1'b0;
            dispense_item_q <= 2'd0;
            deny_q          <= 1'b0;
            coin_return_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (refund_go) begin
                        // Whole balance moves into the dispenser
                        state_q       <= ST_CHANGE;
                        credit_q      <= '0;
                        coin_return_q <= coin_any;
                    end else begin
                        if (buy) begin
                            dispense_q      <= buy_ok;
                            dispense_item_q <= buy_ok ? item_sel : 2'd0;
                            deny_q          <= !buy_ok;
                        end
                        credit_q      <= coin_ok ? coin_total[CREDIT_W-1:0] : post_buy;
                        coin_return_q <= coin_any && !coin_ok;
                    end
                end
                ST_CHANGE: begin
                    coin_return_q <= coin_any;
                    deny_q        <= buy;
                    if (chg_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    change_dispenser u_change (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (refund_go),
        .amount_i     (credit_q),
        .change_500_o (change_500),
        .change_100_o (change_100),
        .busy_o       (chg_busy),
        .remaining_o  (chg_remaining),
        .done_o       (chg_done)
    );

    // While paying out, the visible credit is what is still owed
    assign credit        = chg_busy ? chg_remaining : credit_q;
    assign busy          = chg_busy;
    assign dispense      = dispense_q;
    assign dispense_item = dispense_item_q;
    assign deny          = deny_q;
    assign coin_return   = coin_return_q;

endmodule
